// File: rtl/gpr_scoreboard.sv
// General-purpose register file with write-through bypass and a per-register
// pending-write scoreboard; a post-reset sweep zeroes every register before use.
module gpr_scoreboard #(
    parameter  int WIDTH = 32,
    parameter  int NUM   = 32,
    parameter  int NR    = 2,
    localparam int AW    = $clog2(NUM)
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic                ready,
    input  logic [NR*AW-1:0]    addr_r,
    output logic [NR*WIDTH-1:0] data_r,
    output logic [NR-1:0]       busy_r,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [WIDTH-1:0]    wb_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr
);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    clr_idx_q, clr_idx_d;
    logic [NUM-1:0]   busy_q, busy_d;
    logic [WIDTH-1:0] mem_q [NUM];

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_idx_q <= AW'(1);
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + AW'(1);
            if (clr_idx_q == AW'(NUM - 1)) state_d = RUN;
        end
    end

    always_comb begin
        ready     = (state_q == RUN);
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        busy_d    = busy_q;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx_q;
        end else begin
            if (wb_en && wb_addr != '0) begin
                mem_we    = 1'b1;
                mem_waddr = wb_addr;
                mem_wdata = wb_data;
            end
            // Clear first so a same-cycle issue to the same register wins.
            if (wb_en) busy_d[wb_addr] = 1'b0;
            if (iss_en && iss_addr != '0) busy_d[iss_addr] = 1'b1;
        end
    end

    // Register storage has no reset; only the CLEAR sweep zeroes it.
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        data_r = '0;
        busy_r = '0;
        if (state_q == RUN) begin
            for (int unsigned k = 0; k < NR; k++) begin
                if (addr_r[k*AW +: AW] != '0) begin
                    if (wb_en && wb_addr == addr_r[k*AW +: AW]) begin
                        data_r[k*WIDTH +: WIDTH] = wb_data;
                        busy_r[k]                = 1'b0;
                    end else begin
                        data_r[k*WIDTH +: WIDTH] = mem_q[addr_r[k*AW +: AW]];
                        busy_r[k]                = busy_q[addr_r[k*AW +: AW]];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Randomised bench for gpr_scoreboard: a behavioural register/scoreboard model
// is checked every cycle, plus directed literal checks pinning key scenarios.
module tb_gpr_scoreboard;

    localparam int WIDTH = 32;
    localparam int NUM   = 32;
    localparam int NR    = 2;
    localparam int AW    = $clog2(NUM);

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                ready;
    logic [NR*AW-1:0]    addr_r = '0;
    logic [NR*WIDTH-1:0] data_r;
    logic [NR-1:0]       busy_r;
    logic                wb_en = 1'b0;
    logic [AW-1:0]       wb_addr = '0;
    logic [WIDTH-1:0]    wb_data = '0;
    logic                iss_en = 1'b0;
    logic [AW-1:0]       iss_addr = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    gpr_scoreboard #(.WIDTH(WIDTH), .NUM(NUM), .NR(NR)) dut (
        .clock(clock), .reset_n(reset_n), .ready(ready),
        .addr_r(addr_r), .data_r(data_r), .busy_r(busy_r),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    // Behavioural model: edges since reset, register contents and pending flags.
    int               m_edges = 0;
    logic [WIDTH-1:0] m_mem  [NUM];
    bit               m_busy [NUM];

    function automatic bit m_ready();
        return m_edges >= NUM - 1;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_edges = 0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else if (!m_ready()) begin
            m_edges++;
            if (m_ready()) foreach (m_mem[i]) m_mem[i] = '0;
        end else begin
            if (wb_en && wb_addr != 0) m_mem[wb_addr] = wb_data;
            if (wb_en) m_busy[wb_addr] = 1'b0;
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] ed;
        bit               eb;
        check("model_ready", {63'd0, ready}, {63'd0, m_ready()});
        for (int k = 0; k < NR; k++) begin
            a = addr_r[k*AW +: AW];
            if (!m_ready() || a == 0) begin
                ed = '0; eb = 1'b0;
            end else if (wb_en && wb_addr == a) begin
                ed = wb_data; eb = 1'b0;
            end else begin
                ed = m_mem[a]; eb = m_busy[a];
            end
            check("model_data", {32'd0, data_r[k*WIDTH +: WIDTH]}, {32'd0, ed});
            check("model_busy", {63'd0, busy_r[k]}, {63'd0, eb});
        end
    end

    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                        input logic ie, input logic [AW-1:0] ia,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        @(posedge clock); #1;
        wb_en = we; wb_addr = wa; wb_data = wd;
        iss_en = ie; iss_addr = ia;
        addr_r = {a1, a0};
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1;
        reset_n = 1'b0;
        wb_en = 1'b0; iss_en = 1'b0;
        #2;
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_busy", {62'd0, busy_r}, 64'd0);
        #3 reset_n = 1'b1;
    endtask

    // Counts edges after reset release while driving junk writes/issues.
    task automatic sweep_and_check();
        for (int e = 1; e <= NUM - 1; e++) begin
            @(posedge clock); #1;
            if (e < NUM - 1) begin
                wb_en = 1'b1; wb_addr = AW'($urandom); wb_data = $urandom;
                iss_en = 1'b1; iss_addr = AW'($urandom);
                addr_r = NR*AW'($urandom);
            end else begin
                wb_en = 1'b0; iss_en = 1'b0;
            end
            #1;
            if (e == 1 || e == NUM - 2) check("ready_low_in_clear", {63'd0, ready}, 64'd0);
            if (e == NUM - 1)           check("ready_after_sweep", {63'd0, ready}, 64'd1);
        end
    endtask

    initial begin
        #12 reset_n = 1'b1;
        sweep_and_check();

        for (int i = 0; i < NUM; i += 2) begin
            step(0, 0, 0, 0, 0, AW'(i), AW'(i + 1));
            #1;
            check("zero_after_clear0", {32'd0, data_r[WIDTH-1:0]}, 64'd0);
            check("zero_after_clear1", {32'd0, data_r[2*WIDTH-1:WIDTH]}, 64'd0);
        end

        step(1, 5, 32'hDEADBEEF, 0, 0, 5, 0); #1;
        check("bypass_x5", {32'd0, data_r[WIDTH-1:0]}, 64'hDEADBEEF);
        step(0, 0, 0, 0, 0, 5, 5); #1;
        check("stored_x5_p0", {32'd0, data_r[WIDTH-1:0]}, 64'hDEADBEEF);
        check("stored_x5_p1", {32'd0, data_r[2*WIDTH-1:WIDTH]}, 64'hDEADBEEF);

        step(1, 0, 32'h1234, 0, 0, 5, 0); #1;
        check("x0_bypass", {32'd0, data_r[2*WIDTH-1:WIDTH]}, 64'd0);
        step(0, 0, 0, 0, 0, 5, 0); #1;
        check("x0_after", {32'd0, data_r[2*WIDTH-1:WIDTH]}, 64'd0);

        step(0, 0, 0, 1, 7, 7, 0);
        step(0, 0, 0, 0, 0, 7, 0); #1;
        check("busy_x7_set", {63'd0, busy_r[0]}, 64'd1);
        step(1, 7, 32'h55, 0, 0, 7, 0); #1;
        check("busy_x7_wb_cycle", {63'd0, busy_r[0]}, 64'd0);
        step(0, 0, 0, 0, 0, 7, 0); #1;
        check("busy_x7_after", {63'd0, busy_r[0]}, 64'd0);
        check("data_x7", {32'd0, data_r[WIDTH-1:0]}, 64'h55);

        step(1, 9, 32'hA, 1, 9, 9, 0);
        step(0, 0, 0, 0, 0, 9, 9); #1;
        check("iss_wins_busy_x9", {63'd0, busy_r[1]}, 64'd1);
        check("iss_wins_data_x9", {32'd0, data_r[2*WIDTH-1:WIDTH]}, 64'hA);

        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0); #1;
        check("busy_x0_never", {62'd0, busy_r}, 64'd0);

        for (int c = 0; c < 1500; c++) begin
            step(1'($urandom), AW'($urandom_range(0, 7)), $urandom,
                 1'($urandom), AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end

        pulse_reset();
        repeat (9) @(posedge clock);
        pulse_reset();
        sweep_and_check();
        step(0, 0, 0, 1, 3, 3, 0);
        step(0, 0, 0, 0, 0, 3, 0); #1;
        check("busy_x3_set", {63'd0, busy_r[0]}, 64'd1);
        pulse_reset();
        sweep_and_check();
        step(0, 0, 0, 0, 0, 3, 3); #1;
        check("busy_x3_cleared", {62'd0, busy_r}, 64'd0);

        for (int c = 0; c < 300; c++) begin
            step(1'($urandom), AW'($urandom), $urandom, 1'($urandom), AW'($urandom),
                 AW'($urandom), AW'($urandom));
        end
        step(0, 0, 0, 0, 0, 0, 0);
        @(posedge clock); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
